// File: rtl/ps2_mouse_pkg.sv
// Shared PS/2 mouse definitions: packetizer states, status-byte
// bit positions (also used by the PS/2 parser) and delta limits.
package ps2_mouse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_STATUS,
    SEND_X,
    SEND_Y
  } pkt_state_e;

  localparam int STAT_LEFT  = 0;
  localparam int STAT_RIGHT = 1;
  localparam int STAT_MID   = 2;
  localparam int STAT_ONE   = 3;
  localparam int STAT_XSIGN = 4;
  localparam int STAT_YSIGN = 5;
  localparam int STAT_XOVF  = 6;
  localparam int STAT_YOVF  = 7;

  localparam logic signed [9:0] DELTA_MAX = 10'sd255;
  localparam logic signed [9:0] DELTA_MIN = -10'sd256;

  function automatic logic [7:0] status_byte(
    input logic       l,
    input logic       r,
    input logic       m,
    input logic [8:0] dx,
    input logic [8:0] dy,
    input logic       xo,
    input logic       yo
  );
    logic [7:0] b;
    b             = '0;
    b[STAT_LEFT]  = l;
    b[STAT_RIGHT] = r;
    b[STAT_MID]   = m;
    b[STAT_ONE]   = 1'b1;
    b[STAT_XSIGN] = dx[8];
    b[STAT_YSIGN] = dy[8];
    b[STAT_XOVF]  = xo;
    b[STAT_YOVF]  = yo;
    return b;
  endfunction

endpackage

// File: rtl/ps2_delta_accumulator.sv
// One axis of movement accumulation: 9-bit two's-complement sum
// saturated to the PS/2 range, with a sticky overflow flag.
module ps2_delta_accumulator
  import ps2_mouse_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       add,
  input  logic       clear,
  input  logic [8:0] delta,
  output logic [8:0] acc,
  output logic       ovf,
  output logic [8:0] sum,
  output logic       sum_ovf
);

  logic signed [9:0] wide;

  // Saturated acc + delta, evaluated every cycle for the launch path.
  always_comb begin
    wide    = $signed({acc[8], acc}) + $signed({delta[8], delta});
    sum     = wide[8:0];
    sum_ovf = ovf;
    if (wide > DELTA_MAX) begin
      sum     = DELTA_MAX[8:0];
      sum_ovf = 1'b1;
    end else if (wide < DELTA_MIN) begin
      sum     = DELTA_MIN[8:0];
      sum_ovf = 1'b1;
    end
  end

  // Clear wins over add; a move on the clear edge starts a fresh sum.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= add ? delta : '0;
      ovf <= 1'b0;
    end else if (add) begin
      acc <= sum;
      ovf <= sum_ovf;
    end
  end

endmodule

// File: rtl/ps2_mouse_packetizer.sv
// Turns mouse moves into 3-byte PS/2 packets (status, X, Y).
// Define PS2_PKT_ACCUM_EN to accumulate moves while a packet is sent.
module ps2_mouse_packetizer
  import ps2_mouse_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       left_button,
  input  logic       right_button,
  input  logic       middle_button,
  input  logic [8:0] move_delta_x,
  input  logic [8:0] move_delta_y,
  input  logic       move_valid,
  output logic       move_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  pkt_state_e state;
  logic       accept;
  logic       tx_fire;
  logic       launch;
  logic [7:0] pkt_x;
  logic [7:0] pkt_y;
  logic [8:0] snap_x;
  logic [8:0] snap_y;
  logic       snap_l;
  logic       snap_r;
  logic       snap_m;
  logic       snap_xo;
  logic       snap_yo;

  assign accept  = move_valid & move_ready;
  assign tx_fire = tx_valid & tx_ready;
  assign busy    = (state != IDLE);

`ifdef PS2_PKT_ACCUM_EN
  logic       pending;
  logic       btn_l;
  logic       btn_r;
  logic       btn_m;
  logic       launch_idle;
  logic       launch_y;
  logic       acc_add;
  logic [8:0] acc_x;
  logic [8:0] acc_y;
  logic [8:0] sum_x;
  logic [8:0] sum_y;
  logic       ovf_x;
  logic       ovf_y;
  logic       sovf_x;
  logic       sovf_y;

  assign move_ready  = 1'b1;
  assign launch_idle = (state == IDLE) && (pending || accept);
  assign launch_y    = (state == SEND_Y) && tx_fire && pending;
  assign launch      = launch_idle | launch_y;
  assign acc_add     = accept & ~launch_idle;

  ps2_delta_accumulator u_acc_x (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .add      (acc_add),
    .clear    (launch),
    .delta    (move_delta_x),
    .acc      (acc_x),
    .ovf      (ovf_x),
    .sum      (sum_x),
    .sum_ovf  (sovf_x)
  );

  ps2_delta_accumulator u_acc_y (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .add      (acc_add),
    .clear    (launch),
    .delta    (move_delta_y),
    .acc      (acc_y),
    .ovf      (ovf_y),
    .sum      (sum_y),
    .sum_ovf  (sovf_y)
  );

  // An IDLE launch folds in the move arriving on that same edge.
  always_comb begin
    snap_x  = acc_x;
    snap_y  = acc_y;
    snap_xo = ovf_x;
    snap_yo = ovf_y;
    snap_l  = btn_l;
    snap_r  = btn_r;
    snap_m  = btn_m;
    if (launch_idle && accept) begin
      snap_x  = sum_x;
      snap_y  = sum_y;
      snap_xo = sovf_x;
      snap_yo = sovf_y;
      snap_l  = left_button;
      snap_r  = right_button;
      snap_m  = middle_button;
    end
  end

  // Track latest buttons and whether unsent movement is waiting.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      btn_l   <= 1'b0;
      btn_r   <= 1'b0;
      btn_m   <= 1'b0;
    end else begin
      if (accept) begin
        btn_l <= left_button;
        btn_r <= right_button;
        btn_m <= middle_button;
      end
      if (launch)      pending <= acc_add;
      else if (accept) pending <= 1'b1;
    end
  end
`else
  assign move_ready = (state == IDLE);
  assign launch     = accept;

  // Without accumulation the accepted move is the packet.
  always_comb begin
    snap_x  = move_delta_x;
    snap_y  = move_delta_y;
    snap_xo = 1'b0;
    snap_yo = 1'b0;
    snap_l  = left_button;
    snap_r  = right_button;
    snap_m  = middle_button;
  end
`endif

  // Packet FSM with registered tx_valid/tx_data.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      pkt_x    <= 8'h00;
      pkt_y    <= 8'h00;
    end else if (launch) begin
      state    <= SEND_STATUS;
      tx_valid <= 1'b1;
      tx_data  <= status_byte(snap_l, snap_r, snap_m,
                              snap_x, snap_y,
                              snap_xo, snap_yo);
      pkt_x    <= snap_x[7:0];
      pkt_y    <= snap_y[7:0];
    end else begin
      unique case (state)
        SEND_STATUS: if (tx_fire) begin
          state   <= SEND_X;
          tx_data <= pkt_x;
        end
        SEND_X: if (tx_fire) begin
          state   <= SEND_Y;
          tx_data <= pkt_y;
        end
        SEND_Y: if (tx_fire) begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packetizer.sv
// Directed checks of the PS/2 mouse packetizer.
// Accumulation cases run when PS2_PKT_ACCUM_EN is defined.
module tb_ps2_mouse_packetizer;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       left_button;
  logic       right_button;
  logic       middle_button;
  logic [8:0] move_delta_x;
  logic [8:0] move_delta_y;
  logic       move_valid;
  logic       move_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_mouse_packetizer dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .left_button   (left_button),
    .right_button  (right_button),
    .middle_button (middle_button),
    .move_delta_x  (move_delta_x),
    .move_delta_y  (move_delta_y),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic move(input logic l, input logic r, input logic m,
                      input logic [8:0] dx, input logic [8:0] dy);
    left_button   = l;
    right_button  = r;
    middle_button = m;
    move_delta_x  = dx;
    move_delta_y  = dy;
    move_valid    = 1'b1;
  endtask

  task automatic byte_is(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {7'h0, tx_valid}, 8'h01);
    check({tag, "_data"}, tx_data, exp);
  endtask

  task automatic idle_is(input string tag);
    check({tag, "_valid"}, {7'h0, tx_valid}, 8'h00);
    check({tag, "_busy"}, {7'h0, busy}, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    tx_ready = 1'b1;
    move_valid = 1'b0;
    move(1'b0, 1'b0, 1'b0, 9'h000, 9'h000);
    move_valid = 1'b0;
    #12;
    check("rst_valid", {7'h0, tx_valid}, 8'h00);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", {7'h0, busy}, 8'h00);
    reset = 1'b0;
    #1;
    check("rel_ready", {7'h0, move_ready}, 8'h01);
    tick();
    check("rel_ready2", {7'h0, move_ready}, 8'h01);

    // basic packet: left, dx=+5, dy=-3
    move(1'b1, 1'b0, 1'b0, 9'h005, 9'h1FD);
    tick();
    move_valid = 1'b0;
    byte_is("basic_stat", 8'h29);
    check("basic_busy", {7'h0, busy}, 8'h01);
    tick();
    byte_is("basic_x", 8'h05);
    tick();
    byte_is("basic_y", 8'hFD);
    tick();
    idle_is("basic_end");

    // backpressure on X byte
    move(1'b0, 1'b1, 1'b0, 9'h005, 9'h002);
    tick();
    move_valid = 1'b0;
    byte_is("bp_stat", 8'h0A);
    tick();
    byte_is("bp_x", 8'h05);
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      byte_is("bp_hold", 8'h05);
    end
    tx_ready = 1'b1;
    tick();
    byte_is("bp_y", 8'h02);
    tick();
    idle_is("bp_end");

    // reset while in SEND_X
    move(1'b1, 1'b0, 1'b0, 9'h011, 9'h000);
    tick();
    move_valid = 1'b0;
    tick();
    byte_is("mid_x", 8'h11);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {7'h0, tx_valid}, 8'h00);
    check("mid_rst_data", tx_data, 8'h00);
    check("mid_rst_busy", {7'h0, busy}, 8'h00);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_is("post_rst");
    end
    // zero-delta button-only move still packetizes
    move(1'b0, 1'b0, 1'b0, 9'h000, 9'h000);
    tick();
    move_valid = 1'b0;
    byte_is("post_stat", 8'h08);
    tick();
    byte_is("post_x", 8'h00);
    tick();
    byte_is("post_y", 8'h00);
    tick();
    idle_is("post_end");

`ifndef PS2_PKT_ACCUM_EN
    // move held while busy waits for IDLE
    move(1'b0, 1'b0, 1'b1, 9'h001, 9'h001);
    tick();
    byte_is("hold_stat", 8'h0C);
    move(1'b0, 1'b0, 1'b0, 9'h1FF, 9'h000);
    check("hold_rdy0", {7'h0, move_ready}, 8'h00);
    tick();
    byte_is("hold_x", 8'h01);
    check("hold_rdy1", {7'h0, move_ready}, 8'h00);
    tick();
    byte_is("hold_y", 8'h01);
    tick();
    idle_is("hold_idle");
    check("hold_rdy2", {7'h0, move_ready}, 8'h01);
    tick();
    move_valid = 1'b0;
    byte_is("hold2_stat", 8'h18);
    tick();
    byte_is("hold2_x", 8'hFF);
    tick();
    byte_is("hold2_y", 8'h00);
    tick();
    idle_is("hold2_end");
`else
    // positive saturation during a stalled packet
    tx_ready = 1'b0;
    move(1'b0, 1'b0, 1'b0, 9'h000, 9'h000);
    tick();
    byte_is("satp_p1", 8'h08);
    check("satp_rdy", {7'h0, move_ready}, 8'h01);
    move(1'b0, 1'b0, 1'b0, 9'd200, 9'h000);
    tick();
    move(1'b0, 1'b0, 1'b0, 9'd100, 9'h000);
    tick();
    move_valid = 1'b0;
    byte_is("satp_stall", 8'h08);
    tx_ready = 1'b1;
    tick();
    byte_is("satp_p1x", 8'h00);
    tick();
    byte_is("satp_p1y", 8'h00);
    tick();
    byte_is("satp_stat", 8'h48);
    tick();
    byte_is("satp_x", 8'hFF);
    tick();
    byte_is("satp_y", 8'h00);
    tick();
    idle_is("satp_end");

    // negative saturation
    tx_ready = 1'b0;
    move(1'b0, 1'b0, 1'b0, 9'h000, 9'h000);
    tick();
    move(1'b0, 1'b0, 1'b0, 9'h138, 9'h000);
    tick();
    tick();
    move_valid = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();
    tick();
    byte_is("satn_stat", 8'h58);
    tick();
    byte_is("satn_x", 8'h00);
    tick();
    tick();
    idle_is("satn_end");

    // back-to-back packets with no gap
    move(1'b0, 1'b0, 1'b0, 9'h003, 9'h000);
    tick();
    move_valid = 1'b0;
    byte_is("b2b_s1", 8'h08);
    tick();
    byte_is("b2b_x1", 8'h03);
    move(1'b0, 1'b0, 1'b0, 9'h007, 9'h000);
    tick();
    byte_is("b2b_y1", 8'h00);
    move(1'b0, 1'b0, 1'b0, 9'h009, 9'h000);
    tick();
    move_valid = 1'b0;
    byte_is("b2b_s2", 8'h08);
    tick();
    byte_is("b2b_x2", 8'h07);
    tick();
    byte_is("b2b_y2", 8'h00);
    tick();
    byte_is("b2b_s3", 8'h08);
    tick();
    byte_is("b2b_x3", 8'h09);
    tick();
    byte_is("b2b_y3", 8'h00);
    tick();
    idle_is("b2b_end");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packetizer.md
PS2_MOUSE_PACKETIZER -- requirements
Module: ps2_mouse_packetizer

Interface
REQ-001 SHALL have port: CLOCK_50  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: left_button, right_button, middle_button  in  1 each  button states sampled with each accepted move.
REQ-004 SHALL have ports: move_delta_x, move_delta_y  in  9 each  two's-complement signed movement.
REQ-005 SHALL have ports: move_valid  in  1; move_ready  out  1  move-input handshake.
REQ-006 SHALL have ports: tx_data  out  8  packet byte; tx_valid  out  1; tx_ready  in  1  byte-output handshake.
REQ-007 SHALL have port: busy  out  1  high whenever state is not IDLE.

Function
REQ-008 SHALL accept a move only on a cycle where move_valid and move_ready are both high.
REQ-009 SHALL transfer a byte only on a cycle where tx_valid and tx_ready are both high; tx_valid SHALL NOT depend combinationally on tx_ready.
REQ-010 SHALL hold tx_data stable, and SHALL NOT drop tx_valid, while tx_valid is high and tx_ready is low.
REQ-011 SHALL use states IDLE, SEND_STATUS, SEND_X, SEND_Y; each SEND state advances only on a byte transfer: SEND_STATUS->SEND_X->SEND_Y.
REQ-012 SHALL emit, in order, one status, one X, and one Y byte per packet.
- Status byte bits: 0 left, 1 right, 2 middle, 3 constant 1, 4 X sign, 5 Y sign, 6 X overflow, 7 Y overflow.
- X byte = X delta[7:0]; Y byte = Y delta[7:0].
REQ-013 SHALL launch a packet from IDLE on the edge after work is pending: snapshot deltas, buttons and overflow into packet registers and enter SEND_STATUS; tx_valid high with the status byte one cycle after acceptance (latency 1).
REQ-014 SHALL, on the SEND_Y transfer edge, enter SEND_STATUS with a fresh snapshot if work is pending, otherwise IDLE (no gap cycle between back-to-back packets).
REQ-015 SHALL treat an accepted move with zero deltas as pending work, so button-only changes produce a packet.
REQ-016 SHALL drive tx_valid low in IDLE; tx_data is don't-care in IDLE.

Reset
REQ-017 SHALL, on reset assertion, immediately force: state IDLE, tx_valid 0, tx_data 8'h00, busy 0, packet registers and accumulators 0, overflow flags 0, pending 0.
REQ-018 SHALL abort any in-flight packet on reset; no partial packet resumes after release.
REQ-019 SHALL drive move_ready 1 on the first cycle after reset release.

Configuration
REQ-020 SHALL support macro PS2_PKT_ACCUM_EN.
- Defined: move_ready held at 1 in all states. Accepted moves add into per-axis 9-bit accumulators. Sums computed in 10 bits, saturated to [-256, +255]. Saturation sets a sticky per-axis overflow flag. The snapshot clears accumulators and flags. A move accepted on the snapshot edge lands in the cleared accumulator and becomes pending for the next packet. Buttons come from the most recently accepted move.
- Undefined: move_ready = (state == IDLE). The accepted move is copied directly into the packet registers. Overflow bits are always 0. No accumulation.

Structure
REQ-021 SHALL place the state encoding, status-bit positions (shared with the PS/2 parser), DELTA_MAX = 255, and DELTA_MIN = -256 in package ps2_mouse_pkg.
REQ-022 SHALL implement the per-axis saturating accumulator as sub-module ps2_delta_accumulator, instantiated twice; it is present only under PS2_PKT_ACCUM_EN.

Verification
REQ-023 Basic packet: move left=1, dx=+5, dy=-3, tx_ready=1 -> bytes 8'h29, 8'h05, 8'hFD on three consecutive cycles; first byte one cycle after acceptance.
REQ-024 Backpressure: tx_ready=0 for 4 cycles during the X byte -> tx_data stays 8'h05 and tx_valid stays 1; the Y byte follows the single transfer.
REQ-025 Saturation (ACCUM_EN): moves dx=+200, then +100, during a stalled packet -> next packet X byte 8'hFF with status bit 6 = 1 and bit 4 = 0; dx=-200 twice -> X byte 8'h00 with bit 4 = 1 and bit 6 = 1.
REQ-026 Back-to-back (ACCUM_EN): move accepted during SEND_X -> second status byte on the cycle after the first Y transfer; a move on the snapshot edge appears in a third packet.
REQ-027 Reset mid-packet: assert reset while in SEND_X -> tx_valid 0 the same cycle; after release, no bytes until a new move is accepted; the next packet starts with a status byte.
REQ-028 Non-accum build: move_ready = 0 while busy; a move held with move_valid=1 is accepted on the first IDLE cycle, and its packet follows with latency 1.
